// File: rtl/spi_reg_target.sv
// spi_reg_target: SPI responder with an 8-bit register file.
// Define SPI_REG_TARGET_ABORT_CNT_EN for the abort counter at 7'h7F.
module spi_reg_target #(
  parameter int         REG_COUNT   = 16,
  parameter logic [7:0] RESET_VALUE = 8'h00,
  parameter int         SYNC_STAGES = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   SCK,
  input  logic                   MOSI,
  input  logic                   CS,
  output logic                   MISO,
  output logic [8*REG_COUNT-1:0] regs_flat,
  output logic                   wr_strobe,
  output logic [6:0]             wr_addr,
  output logic [7:0]             wr_data,
  output logic                   busy
`ifdef SPI_REG_TARGET_ABORT_CNT_EN
  ,
  output logic [7:0]             abort_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_s;
  logic [SYNC_STAGES-1:0] r_mosi_s;
  logic [SYNC_STAGES-1:0] r_cs_s;
  logic                   r_sck_d;
  logic                   r_cs_d;
  logic                   w_sck;
  logic                   w_mosi;
  logic                   w_cs;
  logic                   w_sck_rise;
  logic                   w_sck_fall;
  logic                   w_cs_rise;
  logic                   w_cs_fall;

  state_t     r_state;
  state_t     w_state_nxt;
  logic [2:0] r_bit_cnt;
  logic [6:0] r_cmd;
  logic [6:0] r_rx_sh;
  logic [7:0] r_tx_sh;
  logic       r_wr;
  logic [6:0] r_addr;
  logic       r_miso;
  logic       r_wr_strobe;
  logic [6:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_regs [REG_COUNT];

  logic       w_abort;
  logic       w_cmd_done;
  logic       w_data_done;
  logic       w_addr_ok;
  logic       w_commit;
  logic [6:0] w_cmd_addr;
  logic [7:0] w_wr_val;
  logic [7:0] w_rd_val;

`ifdef SPI_REG_TARGET_ABORT_CNT_EN
  logic [7:0] r_abort_cnt;
  logic       w_is_cnt;
  assign w_is_cnt  = (r_addr == 7'h7F);
  assign abort_cnt = r_abort_cnt;
`endif

  assign w_sck      = r_sck_s[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_s[SYNC_STAGES-1];
  assign w_cs       = r_cs_s[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_d;
  assign w_sck_fall = ~w_sck & r_sck_d;
  assign w_cs_rise  = w_cs & ~r_cs_d;
  assign w_cs_fall  = ~w_cs & r_cs_d;
  assign w_cmd_addr = {r_cmd[5:0], w_mosi};
  assign w_wr_val   = {r_rx_sh, w_mosi};
  assign w_addr_ok  = ({1'b0, r_addr} < 8'(REG_COUNT));

`ifdef SPI_REG_TARGET_ABORT_CNT_EN
  assign w_commit = w_data_done & r_wr & w_addr_ok & ~w_is_cnt;
`else
  assign w_commit = w_data_done & r_wr & w_addr_ok;
`endif

  // Synchronize inputs; CS resets high so a frame needs CS seen low first
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_sck_s  <= '0;
      r_mosi_s <= '0;
      r_cs_s   <= '1;
      r_sck_d  <= 1'b0;
      r_cs_d   <= 1'b1;
    end else begin
      r_sck_s  <= {r_sck_s[SYNC_STAGES-2:0], SCK};
      r_mosi_s <= {r_mosi_s[SYNC_STAGES-2:0], MOSI};
      r_cs_s   <= {r_cs_s[SYNC_STAGES-2:0], CS};
      r_sck_d  <= w_sck;
      r_cs_d   <= w_cs;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // FSM next state plus frame-complete and abort events
  always_comb begin
    w_state_nxt = r_state;
    w_abort     = 1'b0;
    w_cmd_done  = 1'b0;
    w_data_done = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_cs_rise) w_state_nxt = S_ADDR;
      end
      S_ADDR: begin
        if (w_cs_fall) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_sck_fall && r_bit_cnt == 3'd7) begin
          w_cmd_done  = 1'b1;
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_cs_fall) begin
          w_abort     = 1'b1;
          w_state_nxt = S_IDLE;
        end else if (w_sck_fall && r_bit_cnt == 3'd7) begin
          w_data_done = 1'b1;
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (w_cs_fall) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Read mux evaluated on the address completing this clk
  always_comb begin
    w_rd_val = 8'h00;
    for (int i = 0; i < REG_COUNT; i++) begin
      if (w_cmd_addr == 7'(i)) w_rd_val = r_regs[i];
    end
`ifdef SPI_REG_TARGET_ABORT_CNT_EN
    if (w_cmd_addr == 7'h7F) w_rd_val = r_abort_cnt;
`endif
  end

  // Shifters, bit counter, register file and write strobe
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_bit_cnt   <= '0;
      r_cmd       <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_wr        <= 1'b0;
      r_addr      <= '0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int i = 0; i < REG_COUNT; i++) r_regs[i] <= RESET_VALUE;
    end else begin
      r_wr_strobe <= 1'b0;
      if (w_state_nxt != r_state) r_bit_cnt <= '0;
      else if (w_sck_fall)        r_bit_cnt <= r_bit_cnt + 3'd1;
      if (r_state == S_ADDR && w_sck_fall) r_cmd <= w_cmd_addr;
      if (w_cmd_done) begin
        r_wr    <= r_cmd[6];
        r_addr  <= w_cmd_addr;
        r_tx_sh <= w_rd_val;
      end
      if (r_state == S_DATA && w_sck_fall) begin
        r_rx_sh <= w_wr_val[6:0];
        r_tx_sh <= {r_tx_sh[6:0], 1'b0};
      end
      if (w_commit) begin
        r_wr_strobe <= 1'b1;
        r_wr_addr   <= r_addr;
        r_wr_data   <= w_wr_val;
        for (int i = 0; i < REG_COUNT; i++) begin
          if (r_addr == 7'(i)) r_regs[i] <= w_wr_val;
        end
      end
    end
  end

  // Present read bits from SCK rise; quiet outside read data phase
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_miso <= 1'b0;
    end else if (r_state == S_DATA && !r_wr && w_cs) begin
      if (w_sck_rise) r_miso <= r_tx_sh[7];
    end else begin
      r_miso <= 1'b0;
    end
  end

`ifdef SPI_REG_TARGET_ABORT_CNT_EN
  // Saturating abort counter; a write to 7'h7F clears it
  always_ff @(posedge clk) begin
    if (!reset_n)
      r_abort_cnt <= '0;
    else if (w_abort && r_abort_cnt != 8'hFF)
      r_abort_cnt <= r_abort_cnt + 8'd1;
    else if (w_data_done && r_wr && w_is_cnt)
      r_abort_cnt <= '0;
  end
`endif

  for (genvar g = 0; g < REG_COUNT; g++) begin : g_flat
    assign regs_flat[8*g +: 8] = r_regs[g];
  end

  assign MISO      = r_miso;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign busy      = (r_state != S_IDLE);

endmodule

// File: tb/tb_spi_reg_target.sv
// tb_spi_reg_target: directed and random SPI frames
// checked against a register-file model.
`timescale 1ns/1ps
module tb_spi_reg_target;

  localparam int         RC   = 16;
  localparam logic [7:0] RV   = 8'h00;
  localparam int         HALF = 8;
`ifdef SPI_REG_TARGET_ABORT_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            SCK = 1'b0;
  logic            MOSI = 1'b0;
  logic            CS = 1'b0;
  logic            MISO;
  logic [8*RC-1:0] regs_flat;
  logic            wr_strobe;
  logic [6:0]      wr_addr;
  logic [7:0]      wr_data;
  logic            busy;
`ifdef SPI_REG_TARGET_ABORT_CNT_EN
  logic [7:0]      abort_cnt;
`endif

  spi_reg_target #(
    .REG_COUNT  (RC),
    .RESET_VALUE(RV),
    .SYNC_STAGES(2)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .SCK      (SCK),
    .MOSI     (MOSI),
    .CS       (CS),
    .MISO     (MISO),
    .regs_flat(regs_flat),
    .wr_strobe(wr_strobe),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
`ifdef SPI_REG_TARGET_ABORT_CNT_EN
    .abort_cnt(abort_cnt),
`endif
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] m_regs [RC];
  int         m_abort = 0;
  int         strobe_cnt = 0;
  logic [6:0] last_wa = '0;
  logic [7:0] last_wd = '0;
  logic       busy_mid = 1'b0;

  // Strobe monitor: counts high cycles, so a wide pulse counts >1
  always @(negedge clk) begin
    if (wr_strobe === 1'b1) begin
      strobe_cnt++;
      last_wa = wr_addr;
      last_wd = wr_data;
    end
  end

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] model_read(input logic [6:0] a);
    int ai;
    ai = int'(a);
    if (CNT_EN && a == 7'h7F) return 8'(m_abort);
    if (ai < RC) return m_regs[ai];
    return 8'h00;
  endfunction

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    f = '0;
    for (int i = 0; i < RC; i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  // Master side: drive MOSI on SCK rise, sample MISO before SCK fall
  task automatic spi_frame(input logic [15:0] mo,
                           input int nf,
                           input int rst_at,
                           output logic [15:0] got);
    got = '0;
    CS = 1'b1;
    repeat (8) @(negedge clk);
    for (int i = 0; i < nf; i++) begin
      SCK  = 1'b1;
      MOSI = mo[15-i];
      repeat (HALF) @(negedge clk);
      got[15-i] = MISO;
      SCK = 1'b0;
      repeat (HALF) @(negedge clk);
      if (i == 4) busy_mid = busy;
      if (i + 1 == rst_at) begin
        reset_n = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
      end
    end
    CS = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic do_frame(input logic w,
                          input logic [6:0] a,
                          input logic [7:0] d,
                          input int nf,
                          input int rst_at);
    logic [15:0] got;
    logic [15:0] exp;
    logic [7:0]  rv;
    int          s0;
    int          ai;
    int          commit;
    s0     = strobe_cnt;
    ai     = int'(a);
    rv     = model_read(a);
    commit = 0;
    spi_frame({w, a, d}, nf, rst_at, got);
    exp = w ? 16'h0000 : {8'h00, rv};
    for (int i = nf; i < 16; i++) exp[15-i] = 1'b0;
    if (rst_at >= 0) begin
      exp = 16'h0000;
      for (int i = 0; i < RC; i++) m_regs[i] = RV;
      m_abort = 0;
    end else if (nf < 16) begin
      if (m_abort < 255) m_abort++;
    end else if (w) begin
      if (CNT_EN && a == 7'h7F) begin
        m_abort = 0;
      end else if (ai < RC) begin
        m_regs[ai] = d;
        commit = 1;
      end
    end
    chk("miso_bits", 128'(got), 128'(exp));
    chk("strobe_cnt", 128'(strobe_cnt - s0), 128'(commit));
    if (commit != 0) begin
      chk("wr_addr", 128'(last_wa), 128'(a));
      chk("wr_data", 128'(last_wd), 128'(d));
    end
    chk("busy_after", 128'(busy), 128'(0));
    chk("miso_idle", 128'(MISO), 128'(0));
    chk("regs_flat", regs_flat, model_flat());
`ifdef SPI_REG_TARGET_ABORT_CNT_EN
    chk("abort_cnt", 128'(abort_cnt), 128'(m_abort));
`endif
  endtask

  initial begin
    logic       rw;
    logic [6:0] ra;
    logic [7:0] rd;
    int         rn;
    for (int i = 0; i < RC; i++) m_regs[i] = RV;
    repeat (4) @(negedge clk);
    chk("rst_miso", 128'(MISO), 128'(0));
    chk("rst_strobe", 128'(wr_strobe), 128'(0));
    chk("rst_wr_addr", 128'(wr_addr), 128'(0));
    chk("rst_wr_data", 128'(wr_data), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_regs", regs_flat, model_flat());
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    do_frame(1'b1, 7'h05, 8'hA5, 16, -1);
    chk("busy_mid", 128'(busy_mid), 128'(1));
    do_frame(1'b0, 7'h05, 8'h00, 16, -1);
    do_frame(1'b1, 7'h40, 8'h3C, 16, -1);
    do_frame(1'b0, 7'h40, 8'h00, 16, -1);
    do_frame(1'b1, 7'h02, 8'hFF, 10, -1);
    do_frame(1'b1, 7'h02, 8'h11, 16, -1);
    do_frame(1'b1, 7'h0F, 8'h5E, 16, -1);
    do_frame(1'b1, 7'h10, 8'h99, 16, -1);
    do_frame(1'b0, 7'h0F, 8'h00, 16, -1);
    do_frame(1'b0, 7'h10, 8'h00, 16, -1);
    do_frame(1'b0, 7'h02, 8'h00, 16, 3);
    do_frame(1'b1, 7'h07, 8'h5A, 16, 12);
    do_frame(1'b1, 7'h03, 8'h77, 16, -1);
    do_frame(1'b0, 7'h03, 8'h00, 16, -1);
    do_frame(1'b0, 7'h7F, 8'h00, 16, -1);

`ifdef SPI_REG_TARGET_ABORT_CNT_EN
    do_frame(1'b1, 7'h01, 8'h12, 4, -1);
    do_frame(1'b0, 7'h03, 8'h00, 12, -1);
    do_frame(1'b1, 7'h04, 8'h34, 0, -1);
    chk("abort_three", 128'(abort_cnt), 128'(3));
    do_frame(1'b0, 7'h7F, 8'h00, 16, -1);
    do_frame(1'b1, 7'h7F, 8'hC3, 16, -1);
    chk("abort_clear", 128'(abort_cnt), 128'(0));
`endif

    for (int k = 0; k < 36; k++) begin
      rw = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0)
        ra = 7'($urandom_range(0, 127));
      else
        ra = 7'($urandom_range(0, RC - 1));
      rd = 8'($urandom);
      rn = ($urandom_range(0, 5) == 0) ?
           int'($urandom_range(0, 15)) : 16;
      do_frame(rw, ra, rd, rn, -1);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

  initial begin
    #20ms;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
